// File: rtl/fir_mac_sched_if.sv
// Bundles the sample, coefficient, multiplier and output signals of fir_mac_sched.
// The slave modport is the block's view; the master modport is its environment's view.
interface fir_mac_sched_if #(
  parameter int NTAPS = 8,
  parameter int ACC_W = 16 + $clog2(NTAPS)
);
  localparam int AW = $clog2(NTAPS);

  logic                    i_coef_we;
  logic [AW-1:0]           i_coef_addr;
  logic signed [7:0]       i_coef;
  logic                    i_sample_valid;
  logic                    o_sample_ready;
  logic [7:0]              i_sample;
  logic [7:0]              o_mult_a;
  logic signed [7:0]       o_mult_b;
  logic signed [15:0]      i_mult;
  logic                    o_y_valid;
  logic                    i_y_ready;
  logic signed [ACC_W-1:0] o_y;
  logic                    o_busy;

  modport slave (
    input  i_coef_we, i_coef_addr, i_coef, i_sample_valid, i_sample, i_mult, i_y_ready,
    output o_sample_ready, o_mult_a, o_mult_b, o_y_valid, o_y, o_busy
  );

  modport master (
    output i_coef_we, i_coef_addr, i_coef, i_sample_valid, i_sample, i_mult, i_y_ready,
    input  o_sample_ready, o_mult_a, o_mult_b, o_y_valid, o_y, o_busy
  );
endinterface

// File: rtl/fir_mac_sched.sv
// Time-multiplexed FIR MAC sequencer: one sample in, NTAPS multiply-accumulate steps
// on an external shared multiplier, one signed result out over valid/ready.
module fir_mac_sched #(
  parameter int NTAPS = 8,
  parameter int ACC_W = 16 + $clog2(NTAPS)
) (
  input  logic            i_clk,
  input  logic            i_rst,
  fir_mac_sched_if.slave  bus
);
  localparam int TAP_W = $clog2(NTAPS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MAC,
    S_OUT
  } state_e;

  state_e                  state_q, state_d;
  logic [TAP_W-1:0]        tap_q, tap_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [7:0]              x_q    [NTAPS];
  logic signed [7:0]       coef_q [NTAPS];
  logic                    accept;
  logic                    coef_wr;

  // NOTE: every signal written here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_d            = state_q;
    tap_d              = tap_q;
    acc_d              = acc_q;
    accept             = 1'b0;
    coef_wr            = 1'b0;
    bus.o_sample_ready = 1'b0;
    bus.o_y_valid      = 1'b0;
    bus.o_mult_a       = '0;
    bus.o_mult_b       = '0;

    unique case (state_q)
      S_IDLE: begin
        bus.o_sample_ready = 1'b1;
        coef_wr            = bus.i_coef_we && (int'(bus.i_coef_addr) < NTAPS);
        if (bus.i_sample_valid) begin
          accept  = 1'b1;
          acc_d   = '0;
          tap_d   = '0;
          state_d = S_MAC;
        end
      end
      S_MAC: begin
        // The delay line was shifted on the accept edge, so x_q[0] is already the new sample.
        bus.o_mult_a = x_q[tap_q];
        bus.o_mult_b = coef_q[tap_q];
        acc_d        = acc_q + {{(ACC_W-16){bus.i_mult[15]}}, bus.i_mult};
        tap_d        = tap_q + 1'b1;
        if (tap_q == TAP_W'(NTAPS - 1)) begin
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        bus.o_y_valid = 1'b1;
        if (bus.i_y_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.o_y    = acc_q;
  assign bus.o_busy = (state_q != S_IDLE);

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      tap_q   <= '0;
      acc_q   <= '0;
      // NOTE: the delay line and coefficient bank are small register arrays that must
      // read back as zero after reset, so they are cleared here rather than left to RAM.
      for (int i = 0; i < NTAPS; i++) begin
        x_q[i]    <= '0;
        coef_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      tap_q   <= tap_d;
      acc_q   <= acc_d;
      if (accept) begin
        x_q[0] <= bus.i_sample;
        for (int i = 1; i < NTAPS; i++) begin
          x_q[i] <= x_q[i-1];
        end
      end
      if (coef_wr) begin
        coef_q[bus.i_coef_addr] <= bus.i_coef;
      end
    end
  end
endmodule

// File: doc/fir_mac_sched.md
# fir_mac_sched

Time-multiplexed MAC sequencer for the high-pass FIR path. It accepts one unsigned 8-bit sample, shifts it into an NTAPS-deep delay line, and steps a single shared 8×8 (unsigned × signed) multiplier across all taps. It accumulates the products and emits one signed filter output per sample over a valid/ready handshake. The multiplier sits outside this block, so the exact or an approximate multiplier variant can be swapped in without touching the controller.

## Interface
- NTAPS, 8, number of filter taps (≥2)
- ACC_W, 16+$clog2(NTAPS) (19 at default), accumulator/output width, signed
- i_clk  in  1  clock, all logic rising-edge
- i_rst  in  1  reset, synchronous, active-high
- i_coef_we  in  1  coefficient write strobe
- i_coef_addr  in  $clog2(NTAPS)  coefficient index
- i_coef  in  8  signed coefficient
- i_sample_valid  in  1  input sample valid
- o_sample_ready  out  1  block can accept a sample
- i_sample  in  8  unsigned input sample
- o_mult_a  out  8  unsigned operand to shared multiplier
- o_mult_b  out  8  signed operand to shared multiplier
- i_mult  in  16  signed product from multiplier (combinational, same cycle)
- o_y_valid  out  1  output valid
- i_y_ready  in  1  downstream accepts output
- o_y  out  ACC_W  signed filter output
- o_busy  out  1  state ≠ IDLE

## Operation
- Storage:
  - coef[0..NTAPS-1], 8-bit signed.
  - x[0..NTAPS-1], 8-bit unsigned, where x[0] is the newest sample.
  - acc, ACC_W signed.
  - tap counter, $clog2(NTAPS) bits.
- FSM states are IDLE, MAC and OUT.
- IDLE:
  - o_sample_ready=1.
  - On i_sample_valid&o_sample_ready:
    - x[k]←x[k-1] for k≥1, and x[0]←i_sample.
    - acc←0 and tap←0.
    - Go to MAC.
- MAC:
  - o_mult_a=x[tap] and o_mult_b=coef[tap]. x[tap] already reflects the shifted delay line.
  - Each cycle: acc←acc+signext(i_mult, ACC_W), and tap←tap+1.
  - At tap==NTAPS-1, perform the final add and go to OUT.
- OUT:
  - o_y_valid=1, with o_y=acc.
  - When i_y_ready=1, go to IDLE.
  - o_y is held stable while o_y_valid=1 and i_y_ready=0.
- Outside MAC, o_mult_a and o_mult_b are 0.
- Arithmetic:
  - The product is sign-extended before accumulation.
  - ACC_W guarantees no overflow: |sum| ≤ NTAPS·255·128.
  - There is no saturation and no rounding.
- Coefficient writes:
  - Accepted only in IDLE: coef[i_coef_addr]←i_coef.
  - Ignored in MAC and OUT.
  - A write and a sample accept in the same IDLE cycle both take effect. The new coefficient is used by that sample's MAC pass.
  - i_coef_addr ≥ NTAPS is ignored.
- o_sample_ready=0 in MAC and OUT. i_sample is not sampled in those states, and the delay line is unchanged.

## Timing
- Sample accepted at edge T → MAC occupies cycles T+1..T+NTAPS → o_y_valid=1 from cycle T+NTAPS+1.
  - Latency is NTAPS+1 cycles.
  - Peak throughput is one sample per NTAPS+2 cycles when i_y_ready is held high. The cycle after the OUT handshake is IDLE.
- The output handshake completes on the edge where o_y_valid&i_y_ready=1. o_y_valid drops on the following cycle.
- Reset values:
  - state=IDLE, o_sample_ready=1, o_y_valid=0, o_y=0, o_busy=0.
  - o_mult_a=0, o_mult_b=0.
  - All x[]=0, all coef[]=0, acc=0, tap=0.
- Reset asserted mid-MAC or mid-OUT aborts the pass. The partial result is discarded, and the state returns to the reset values on the next edge.
- Reset dominates concurrent sample, coefficient or output handshakes.

## Test plan
- Impulse response:
  - Stimulus: coef={1,2,3,4,5,6,7,8}; send sample 1 then seven 0s, with i_y_ready=1.
  - Required: outputs 1,2,3,4,5,6,7,8 in order.
  - Required: each o_y_valid rises exactly 9 cycles after its accept edge.
- Extremes:
  - Stimulus: all coef=−128; send eight samples of 255.
  - Required: 8th output = −261120, which fits in 19-bit signed.
  - Stimulus: all coef=127; send eight samples of 255.
  - Required: 8th output = 259080.
- Backpressure:
  - Stimulus: hold i_y_ready=0 for 5 cycles in OUT.
  - Required: o_y and o_y_valid are stable, o_sample_ready=0, and a presented sample is not taken.
  - Required: after i_y_ready=1, the next sample is accepted and processed with the correct history.
- Coefficient write while busy:
  - Stimulus: write coef[0]=50 during MAC.
  - Required: the current and following outputs use the old coef[0].
  - Stimulus: repeat the write in IDLE.
  - Required: the new value is used by the next pass.
- Reset mid-MAC:
  - Stimulus: assert i_rst at tap 3.
  - Required: next cycle o_busy=0, o_y_valid=0, and all outputs are at reset values.
  - Required: the impulse test rerun after reset yields only zeros until coefficients are rewritten.
- Multiplier operand trace:
  - Check: over one pass, (o_mult_a, o_mult_b) sequence equals (x[k], coef[k]) for k=0..7.
  - Check: operands are 0 in IDLE and OUT.
